fifo_peer_port: RTL and testbench
=================================

# fifo_peer_port

Synchronous FPGA-side port for the two external FIFOs that sit behind the FT2232H bridge. It drains FIFO A, which the host-to-FIFO path fills, and presents each word on an internal valid/ready stream. It also takes words from an internal valid/ready stream and writes them into FIFO B, which the FIFO-to-host path empties. Both FIFOs share one strobe sequencer, and the block arbitrates between them.

## Interface
- DW, 8: data width of FIFO A, FIFO B and both internal streams.
- STROBE_CYC, 2: length of each RA/WB low pulse in clk cycles (≥1).
- GAP_CYC, 3: idle cycles after every access before the next decision (≥2, must cover flag synchronizer depth plus one).

- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- EFA  in  1  FIFO A empty flag, active low (0 = empty); asynchronous.
- QA  in  DW  FIFO A read data; valid while RA is low.
- RA  out  1  FIFO A read strobe, active low.
- FFB  in  1  FIFO B full flag, active low (0 = full); asynchronous.
- DB  out  DW  FIFO B write data.
- DB_OE  out  1  DB output enable.
- WB  out  1  FIFO B write strobe, active low.
- rx_data  out  DW  word read from FIFO A.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data.
- tx_data  in  DW  word to write to FIFO B.
- tx_valid  in  1  tx_data is offered.
- tx_ready  out  1  word accepted this cycle.

## Operation
- EFA and FFB each pass through a 2-flop synchronizer giving efa_s and ffb_s. Both synchronizer flops reset to 0, so both FIFOs read as empty/full until real flags propagate.
- States: IDLE, RD_STB, WR_SETUP, WR_STB, WR_HOLD, GAP.
- read_ok = efa_s & ~rx_valid.
- write_ok = ffb_s & tx_valid.
- In IDLE:
  - If only read_ok, go to RD_STB.
  - If only write_ok, go to WR_SETUP.
  - If both, serve the operation not served last. A last_op bit holds this; it resets to "write", so the first contested decision is a read.
  - If neither, stay in IDLE.
- Read path:
  - RA is driven low for the whole of RD_STB, which lasts STROBE_CYC cycles.
  - On the edge that leaves RD_STB: rx_data <= QA, rx_valid <= 1, RA <= 1, next state GAP.
- rx_valid clears on a cycle with rx_valid & rx_ready. rx_data holds its value until the next read.
- Write path:
  - tx_ready = 1 combinationally, only in the IDLE cycle where the write is chosen. Otherwise tx_ready = 0.
  - On that edge: DB <= tx_data, DB_OE <= 1, next state WR_SETUP.
  - WR_SETUP lasts 1 cycle with WB high.
  - WR_STB lasts STROBE_CYC cycles with WB low.
  - WR_HOLD lasts 1 cycle with WB high and DB held.
  - Then GAP; DB_OE <= 0 on entering GAP.
- GAP lasts GAP_CYC cycles with both strobes high, then returns to IDLE. This lets the synchronized flags reflect the access just completed.
- RA and WB come straight from flops and are never low simultaneously.
- DB changes only while DB_OE = 0 or in the edge entering WR_SETUP.
- Cycle counters are sized to max(STROBE_CYC, GAP_CYC) and saturate at their terminal count.

## Timing
- Reset values (asynchronous on rst_n low):
  - RA = 1, WB = 1, DB_OE = 0, DB = 0.
  - rx_valid = 0, rx_data = 0, tx_ready = 0.
  - State IDLE, last_op = write, counters 0.
- Reset mid-access drops strobes immediately. A partially read word is discarded; a write in flight is abandoned with tx already accepted.
- Flag to action: an EFA rise at edge k gives efa_s = 1 after edge k+2, and RA falls at edge k+3 at the earliest.
- Read, with the IDLE decision at cycle n:
  - RA = 0 during cycles n+1 … n+STROBE_CYC.
  - rx_valid = 1 from cycle n+STROBE_CYC+1.
  - Next decision at cycle n+STROBE_CYC+GAP_CYC+1.
- Write, with acceptance at cycle n:
  - DB valid from n+1.
  - WB = 0 during n+2 … n+1+STROBE_CYC.
  - DB held through n+2+STROBE_CYC.
  - Next decision at n+3+STROBE_CYC+GAP_CYC.
- Defaults give 6 cycles per read and 8 per write.
- The flag is sampled only in IDLE. A flag change during a strobe or GAP takes effect at the next decision.

## Test plan
- Reset, then EFA = 1, rx_ready = 1, QA = 0xA5:
  - RA low exactly 2 cycles, starting 3 cycles after the first active edge.
  - rx_data = 0xA5, rx_valid pulses, next RA falls 6 cycles after the previous one.
- FFB = 1, tx_valid held with data 0x3C, 0x3D:
  - tx_ready one cycle per word, DB = 0x3C with WB low 2 cycles, setup/hold ≥1 cycle each.
  - Second WB falls 8 cycles after the first.
- EFA = 1, FFB = 1, tx_valid = 1, rx_ready = 1:
  - Accesses alternate R, W, R, W; RA and WB are never low together.
- rx_ready = 0 with EFA = 1:
  - Exactly one read occurs, then RA stays high.
  - Raising rx_ready resumes reads after rx_valid clears.
- Deassert rst_n during WR_STB:
  - WB, DB_OE and tx_ready return to reset values asynchronously.
  - After release there is no access until flags resynchronize (≥3 cycles).

Source files
------------

// File: rtl/fifo_peer_port.sv
// Port between two external FT2232H-side FIFOs (A drained to rx stream, B filled from tx stream).
// One shared strobe sequencer: read = 1+STROBE_CYC+GAP_CYC cycles, write = 3+STROBE_CYC+GAP_CYC; rx/tx use valid/ready.
module fifo_peer_port #(
  parameter int DW         = 8,
  parameter int STROBE_CYC = 2,
  parameter int GAP_CYC    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          EFA,
  input  logic [DW-1:0] QA,
  output logic          RA,
  input  logic          FFB,
  output logic [DW-1:0] DB,
  output logic          DB_OE,
  output logic          WB,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_ready,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready
);

  localparam int MAXC = (STROBE_CYC > GAP_CYC) ? STROBE_CYC : GAP_CYC;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] STB_TC  = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] GAP_TC  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAXC);

  typedef enum logic [2:0] {IDLE, RD_STB, WR_SETUP, WR_STB, WR_HOLD, GAP} state_t;

  state_t          state_q, state_d;
  logic            efa_m_q, efa_s_q, ffb_m_q, ffb_s_q;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            last_wr_q, last_wr_d;
  logic            ra_q, ra_d, wb_q, wb_d;
  logic            db_oe_q, db_oe_d;
  logic            rx_valid_q, rx_valid_d;
  logic [DW-1:0]   db_q, db_d, rx_data_q, rx_data_d;
  logic            read_ok, write_ok, pick_rd, pick_wr;

  always_comb begin
    read_ok  = efa_s_q & ~rx_valid_q;
    write_ok = ffb_s_q & tx_valid;
    // On contention serve whichever direction was not served last.
    pick_rd  = read_ok & (~write_ok | last_wr_q);
    pick_wr  = write_ok & (~read_ok | ~last_wr_q);
    cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    state_d    = state_q;
    cnt_d      = cnt_q;
    last_wr_d  = last_wr_q;
    ra_d       = ra_q;
    wb_d       = wb_q;
    db_oe_d    = db_oe_q;
    db_d       = db_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q & ~rx_ready;
    tx_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_rd) begin
          state_d   = RD_STB;
          ra_d      = 1'b0;
          cnt_d     = '0;
          last_wr_d = 1'b0;
        end else if (pick_wr) begin
          tx_ready  = 1'b1;
          db_d      = tx_data;
          db_oe_d   = 1'b1;
          state_d   = WR_SETUP;
          last_wr_d = 1'b1;
        end
      end
      RD_STB: begin
        if (cnt_q == STB_TC) begin
          ra_d       = 1'b1;
          rx_data_d  = QA;
          rx_valid_d = 1'b1;
          state_d    = GAP;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WR_SETUP: begin
        wb_d    = 1'b0;
        cnt_d   = '0;
        state_d = WR_STB;
      end
      WR_STB: begin
        if (cnt_q == STB_TC) begin
          wb_d    = 1'b1;
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WR_HOLD: begin
        db_oe_d = 1'b0;
        cnt_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        // Lets the synchronized flags catch up with the access just finished.
        if (cnt_q == GAP_TC) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      efa_m_q    <= 1'b0;
      efa_s_q    <= 1'b0;
      ffb_m_q    <= 1'b0;
      ffb_s_q    <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_wr_q  <= 1'b1;
      ra_q       <= 1'b1;
      wb_q       <= 1'b1;
      db_oe_q    <= 1'b0;
      db_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      efa_m_q    <= EFA;
      efa_s_q    <= efa_m_q;
      ffb_m_q    <= FFB;
      ffb_s_q    <= ffb_m_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_wr_q  <= last_wr_d;
      ra_q       <= ra_d;
      wb_q       <= wb_d;
      db_oe_q    <= db_oe_d;
      db_q       <= db_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign RA       = ra_q;
  assign WB       = wb_q;
  assign DB       = db_q;
  assign DB_OE    = db_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_fifo_peer_port.sv
// Bench for fifo_peer_port: per-reset scenario table plus reset/backpressure sequences,
// with queue scoreboards for FIFO A words and tx words.
module tb_fifo_peer_port;
  localparam int DW = 8, SC = 2, GC = 3;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          EFA = 1'b0, FFB = 1'b0, rx_ready = 1'b0, tx_valid = 1'b0;
  logic [DW-1:0] QA = '0, tx_data = '0;
  logic          RA, WB, DB_OE, rx_valid, tx_ready;
  logic [DW-1:0] DB, rx_data;

  fifo_peer_port #(.DW(DW), .STROBE_CYC(SC), .GAP_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .EFA(EFA), .QA(QA), .RA(RA), .FFB(FFB),
    .DB(DB), .DB_OE(DB_OE), .WB(WB), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  int cyc, n_ra, n_wb, first_ra, first_wb, ra_run, wb_run;
  bit overlap, tx_adv;
  logic ra_prev, wb_prev, oe_prev;
  logic [DW-1:0] db_at_fall;
  logic [DW-1:0] rx_exp_q[$], tx_exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Holds reset for two edges, releases it 1ns after an edge; edge counting restarts at 0.
  task automatic apply_reset();
    rst_n = 1'b0;
    rx_exp_q.delete();
    tx_exp_q.delete();
    n_ra = 0; n_wb = 0; first_ra = 0; first_wb = 0;
    ra_run = 0; wb_run = 0; overlap = 0; tx_adv = 0;
    QA = 8'hA5;
    tx_data = 8'h3C;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
    ra_prev = RA; wb_prev = WB; oe_prev = DB_OE;
  endtask

  // One clock: handshakes as seen just before the edge, then the FIFO-side monitor after it.
  task automatic step();
    logic [DW-1:0] e;
    if (rx_valid && rx_ready) begin
      if (rx_exp_q.size() == 0) chk("rx_unexpected_word", 1, 0);
      else begin
        e = rx_exp_q.pop_front();
        chk("rx_data", int'(rx_data), int'(e));
      end
    end
    if (tx_valid && tx_ready) begin
      tx_exp_q.push_back(tx_data);
      tx_adv = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (tx_adv) begin
      tx_data = tx_data + 1'b1;
      tx_adv = 0;
    end
    if (RA === 1'b0 && WB === 1'b0) overlap = 1;
    if (ra_prev && !RA) begin
      n_ra++;
      if (first_ra == 0) first_ra = cyc;
      rx_exp_q.push_back(QA);
      ra_run = 0;
    end
    if (!RA) ra_run++;
    if (!ra_prev && RA) begin
      chk("ra_low_cycles", ra_run, SC);
      chk("rx_valid_after_read", int'(rx_valid), 1);
      QA = QA + 1'b1;
    end
    if (wb_prev && !WB) begin
      n_wb++;
      if (first_wb == 0) first_wb = cyc;
      chk("db_oe_setup", int'(oe_prev), 1);
      if (tx_exp_q.size() == 0) chk("wb_without_tx_accept", 1, 0);
      else begin
        e = tx_exp_q.pop_front();
        chk("db_data", int'(DB), int'(e));
      end
      db_at_fall = DB;
      wb_run = 0;
    end
    if (!WB) wb_run++;
    if (!wb_prev && WB) begin
      chk("wb_low_cycles", wb_run, SC);
      chk("db_oe_hold", int'(DB_OE), 1);
      chk("db_hold", int'(DB), int'(db_at_fall));
    end
    ra_prev = RA; wb_prev = WB; oe_prev = DB_OE;
  endtask

  typedef struct {
    logic efa, ffb, rxr, txv;
    int   ncyc, n_ra, n_wb, first_ra, first_wb;
  } row_t;

  row_t rows[7];

  initial begin
    int start, delta;
    bit found;

    // Reads every 6 edges from edge 3, writes every 8 from edge 4; contested decisions alternate, read first.
    rows[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 40, 7, 0, 3, 0};
    rows[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 40, 0, 5, 0, 4};
    rows[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 40, 3, 3, 3, 10};
    rows[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 40, 1, 0, 3, 0};
    rows[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 40, 0, 0, 0, 0};
    rows[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 40, 0, 0, 0, 0};
    rows[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 40, 1, 4, 3, 10};

    // Reset values while rst_n is held low with live flags and offers.
    EFA = 1'b1; FFB = 1'b1; tx_valid = 1'b1; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_RA", int'(RA), 1);
    chk("rst_WB", int'(WB), 1);
    chk("rst_DB_OE", int'(DB_OE), 0);
    chk("rst_DB", int'(DB), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_tx_ready", int'(tx_ready), 0);

    for (int i = 0; i < 7; i++) begin
      EFA = rows[i].efa; FFB = rows[i].ffb;
      rx_ready = rows[i].rxr; tx_valid = rows[i].txv;
      apply_reset();
      repeat (rows[i].ncyc) step();
      chk($sformatf("row%0d_reads", i), n_ra, rows[i].n_ra);
      chk($sformatf("row%0d_writes", i), n_wb, rows[i].n_wb);
      chk($sformatf("row%0d_first_ra_edge", i), first_ra, rows[i].first_ra);
      chk($sformatf("row%0d_first_wb_edge", i), first_wb, rows[i].first_wb);
      chk($sformatf("row%0d_ra_wb_overlap", i), int'(overlap), 0);
    end

    // Backpressure: one read stalls, then raising rx_ready frees the word and the next read follows 2 edges later.
    EFA = 1'b1; FFB = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0;
    apply_reset();
    repeat (20) step();
    chk("stall_reads", n_ra, 1);
    chk("stall_rx_valid", int'(rx_valid), 1);
    rx_ready = 1'b1;
    start = cyc;
    found = 0;
    for (int k = 0; k < 12 && !found; k++) begin
      step();
      if (n_ra == 2) found = 1;
    end
    delta = cyc - start;
    chk("resume_read_seen", int'(found), 1);
    chk("resume_read_delay", delta, 2);

    // Reset during WR_STB: outputs drop before the next edge, no access until flags resync.
    EFA = 1'b0; FFB = 1'b1; rx_ready = 1'b1; tx_valid = 1'b1;
    apply_reset();
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (WB == 1'b0) found = 1;
    end
    chk("wr_stb_reached", int'(found), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_WB", int'(WB), 1);
    chk("async_rst_DB_OE", int'(DB_OE), 0);
    chk("async_rst_tx_ready", int'(tx_ready), 0);
    chk("async_rst_DB", int'(DB), 0);
    EFA = 1'b1;
    apply_reset();
    repeat (2) step();
    chk("no_access_before_resync", n_ra + n_wb, 0);
    step();
    chk("first_access_after_resync", first_ra, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
